// File: rtl/freq_meter.sv
// freq_meter
// ----------
// Gated frequency counter for one measurement channel. The asynchronous
// sig_in is synchronised, its rising edges are counted over a fixed window
// of GATE_CYCLES clk_clk cycles, and the window total is published on
// freq_out. When GATE_CYCLES equals the clock frequency in Hz, freq_out
// reads directly in Hz.
//
// Ports:
//   clk_clk      in   1      system clock, the only clock
//   reset_reset  in   1      synchronous, active-high reset
//   sig_in       in   1      asynchronous signal under measurement
//   enable       in   1      1 = measure, 0 = freeze gate/edge counters
//   freq_out     out  CNT_W  edge count of the last completed window
//   freq_valid   out  1      one-cycle strobe when freq_out updates
//   overflow     out  1      the window shown on freq_out saturated
//
// Output handshake: freq_valid is a pure strobe with no ready/backpressure.
// It is high for exactly the one cycle in which freq_out and overflow show
// a newly closed window; both hold that value until the next strobe, so a
// consumer may sample them at the strobe or at any later time.

module freq_meter #(
    parameter int unsigned GATE_CYCLES = 50000000,
    parameter int unsigned CNT_W       = 24,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] freq_out,
    output logic             freq_valid,
    output logic             overflow
);

    localparam int unsigned       GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // Synchroniser chain; sync_q[SYNC_STAGES-1] is the settled sample.
    logic [SYNC_STAGES-1:0] sync_q;
    // Previous value of the settled sample, for rising-edge detection.
    logic                   sync_dly;

    logic [GATE_W-1:0]      gate_cnt;
    logic [CNT_W-1:0]       edge_cnt;
    logic                   sat_flag;

    logic                   edge_det;
    logic                   window_close;
    logic                   at_max;
    logic [CNT_W-1:0]       cnt_next;
    logic                   sat_next;

    // Count value and saturation flag including this cycle's edge. The
    // same values feed both the running counter and the published result,
    // so an edge landing in the closing cycle belongs to the closing window.
    always_comb begin
        edge_det     = 1'b0;
        window_close = 1'b0;
        at_max       = 1'b0;
        cnt_next     = edge_cnt;
        sat_next     = sat_flag;

        edge_det     = enable & sync_q[SYNC_STAGES-1] & ~sync_dly;
        window_close = enable && (gate_cnt == GATE_LAST);
        at_max       = (edge_cnt == CNT_MAX);

        if (edge_det) begin
            if (at_max) begin
                sat_next = 1'b1;
            end else begin
                cnt_next = edge_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sync_q     <= '0;
            sync_dly   <= 1'b0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            sat_flag   <= 1'b0;
            freq_out   <= '0;
            freq_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            // The synchroniser and delay register run even while disabled,
            // so re-enabling with sig_in already high does not fake an edge.
            sync_q     <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sync_dly   <= sync_q[SYNC_STAGES-1];
            freq_valid <= window_close;

            if (enable) begin
                if (window_close) begin
                    gate_cnt <= '0;
                end else begin
                    gate_cnt <= gate_cnt + GATE_W'(1);
                end
            end

            if (window_close) begin
                freq_out <= cnt_next;
                overflow <= sat_next;
                edge_cnt <= '0;
                sat_flag <= 1'b0;
            end else if (enable) begin
                edge_cnt <= cnt_next;
                sat_flag <= sat_next;
            end
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter
// -------------
// Bench for freq_meter. Two instances share all inputs: one with a 24-bit
// count and one with a 4-bit count, so saturation is exercised on the same
// stimulus that measures normally on the wide instance. A reference model
// built from the measurement rules (edge seen SYNC_STAGES cycles after
// sig_in rises, counted when enabled, window of GATE_CYCLES enabled
// cycles, result clamped to the counter range) is compared every cycle.

module tb_freq_meter;

    localparam int G     = 100;
    localparam int S     = 2;
    localparam int MAXC  = 20000;
    localparam int MAX_A = (1 << 24) - 1;
    localparam int MAX_B = 15;

    // ---------------- clock / reset / DUT ----------------
    logic        clk_clk = 1'b0;
    logic        reset_reset = 1'b1;
    logic        sig_in = 1'b0;
    logic        enable = 1'b1;
    logic [23:0] freq_a;
    logic        valid_a;
    logic        ovf_a;
    logic [3:0]  freq_b;
    logic        valid_b;
    logic        ovf_b;

    always #5 clk_clk = ~clk_clk;

    freq_meter #(.GATE_CYCLES(G), .CNT_W(24), .SYNC_STAGES(S)) dut_a (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .sig_in      (sig_in),
        .enable      (enable),
        .freq_out    (freq_a),
        .freq_valid  (valid_a),
        .overflow    (ovf_a)
    );

    freq_meter #(.GATE_CYCLES(G), .CNT_W(4), .SYNC_STAGES(S)) dut_b (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .sig_in      (sig_in),
        .enable      (enable),
        .freq_out    (freq_b),
        .freq_valid  (valid_b),
        .overflow    (ovf_b)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Input history indexed by the clock edge that samples it.
    bit sig_h [MAXC];
    bit rst_h [MAXC];
    bit en_h  [MAXC];
    int cyc = 0;

    int m_cnt   = 0;   // unbounded edges in the open window
    int m_pos   = 0;   // enabled cycles elapsed in the open window
    int m_freq_a = 0;
    int m_freq_b = 0;
    bit m_ovf_a = 0;
    bit m_ovf_b = 0;
    bit m_valid = 0;

    function automatic bit reset_between(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (rst_h[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // A rise of sig_in sampled at edge p-S is seen at edge p, provided no
    // reset intervened; a reset at the previous sample makes it read as 0.
    function automatic bit edge_seen(input int p);
        if (p < S + 1) return 1'b0;
        if (!sig_h[p-S]) return 1'b0;
        if (sig_h[p-S-1] && !rst_h[p-S-1]) return 1'b0;
        if (reset_between(p - S, p - 1)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_edge(input int p);
        m_valid = 1'b0;
        if (rst_h[p]) begin
            m_cnt    = 0;
            m_pos    = 0;
            m_freq_a = 0;
            m_freq_b = 0;
            m_ovf_a  = 1'b0;
            m_ovf_b  = 1'b0;
        end else if (en_h[p]) begin
            if (edge_seen(p)) m_cnt++;
            m_pos++;
            if (m_pos == G) begin
                m_valid  = 1'b1;
                m_freq_a = (m_cnt > MAX_A) ? MAX_A : m_cnt;
                m_freq_b = (m_cnt > MAX_B) ? MAX_B : m_cnt;
                m_ovf_a  = (m_cnt > MAX_A);
                m_ovf_b  = (m_cnt > MAX_B);
                m_cnt    = 0;
                m_pos    = 0;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs set by the caller are applied to the next rising edge; outputs
    // are compared 1 time unit after that edge.
    task automatic step();
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, limit %0d", cyc, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        sig_h[cyc] = sig_in;
        rst_h[cyc] = reset_reset;
        en_h[cyc]  = enable;
        @(posedge clk_clk);
        model_edge(cyc);
        cyc++;
        #1;
        chk("valid_a", {31'd0, valid_a}, {31'd0, m_valid});
        chk("valid_b", {31'd0, valid_b}, {31'd0, m_valid});
        chk("freq_a",  {8'd0, freq_a},   m_freq_a);
        chk("freq_b",  {28'd0, freq_b},  m_freq_b);
        chk("ovf_a",   {31'd0, ovf_a},   {31'd0, m_ovf_a});
        chk("ovf_b",   {31'd0, ovf_b},   {31'd0, m_ovf_b});
    endtask

    task automatic do_reset(input int n);
        reset_reset = 1'b1;
        sig_in      = 1'b0;
        enable      = 1'b1;
        repeat (n) step();
        chk("reset_freq", {8'd0, freq_a}, 0);
        chk("reset_valid", {31'd0, valid_a}, 0);
        chk("reset_ovf", {31'd0, ovf_b}, 0);
        reset_reset = 1'b0;
    endtask

    // Square wave, high for the first half of each period; period 0 = low.
    task automatic run_wave(input int period, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            sig_in = (period == 0) ? 1'b0 : ((i % period) < period / 2);
            step();
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int period;
        int exp_a;
        bit ovf_a;
        int exp_b;
        bit ovf_b;
    } vec_t;

    vec_t tbl [8];

    initial begin
        int first_k;
        int got_f;
        int en_hold;
        int sig_hold;
        bit fast;

        tbl[0] = '{period: 10,  exp_a: 10, ovf_a: 0, exp_b: 10, ovf_b: 0};
        tbl[1] = '{period: 2,   exp_a: 50, ovf_a: 0, exp_b: 15, ovf_b: 1};
        tbl[2] = '{period: 20,  exp_a: 5,  ovf_a: 0, exp_b: 5,  ovf_b: 0};
        tbl[3] = '{period: 4,   exp_a: 25, ovf_a: 0, exp_b: 15, ovf_b: 1};
        tbl[4] = '{period: 25,  exp_a: 4,  ovf_a: 0, exp_b: 4,  ovf_b: 0};
        tbl[5] = '{period: 50,  exp_a: 2,  ovf_a: 0, exp_b: 2,  ovf_b: 0};
        tbl[6] = '{period: 100, exp_a: 1,  ovf_a: 0, exp_b: 1,  ovf_b: 0};
        tbl[7] = '{period: 0,   exp_a: 0,  ovf_a: 0, exp_b: 0,  ovf_b: 0};

        // Steady-state windows: the third window after reset is free of
        // start-up effects and holds exactly 100/period edges.
        for (int t = 0; t < 8; t++) begin
            do_reset(2);
            run_wave(tbl[t].period, 3 * G);
            chk("tbl_valid", {31'd0, valid_a}, 1);
            chk("tbl_freq_a", {8'd0, freq_a}, tbl[t].exp_a);
            chk("tbl_ovf_a", {31'd0, ovf_a}, {31'd0, tbl[t].ovf_a});
            chk("tbl_freq_b", {28'd0, freq_b}, tbl[t].exp_b);
            chk("tbl_ovf_b", {31'd0, ovf_b}, {31'd0, tbl[t].ovf_b});
        end

        // Saturating window followed by a slow one on the 4-bit instance.
        do_reset(3);
        run_wave(2, 2 * G);
        chk("sat_freq_b", {28'd0, freq_b}, 15);
        chk("sat_ovf_b", {31'd0, ovf_b}, 1);
        run_wave(20, 2 * G);
        chk("unsat_freq_b", {28'd0, freq_b}, 5);
        chk("unsat_ovf_b", {31'd0, ovf_b}, 0);

        // Six single-cycle pulses, then a rise whose detection coincides with
        // the closing cycle; it belongs to this window, not the next.
        do_reset(3);
        first_k = -1;
        for (int k = 1; k <= G; k++) begin
            sig_in = ((k % 10 == 0) && (k <= 60)) || (k >= 98);
            step();
            if (valid_a && first_k < 0) first_k = k;
        end
        chk("first_close_cycle", first_k, G);
        chk("coincident_freq", {8'd0, freq_a}, 7);
        for (int k = G + 1; k <= 2 * G; k++) begin
            sig_in = (k <= 105);
            step();
        end
        chk("after_coincident_valid", {31'd0, valid_a}, 1);
        chk("after_coincident_freq", {8'd0, freq_a}, 0);

        // Enable dropped for 50 cycles; re-enabled while sig_in is high.
        do_reset(3);
        first_k = -1;
        got_f   = -1;
        for (int k = 1; k <= 2 * G; k++) begin
            sig_in = ((k - 1) % 10) < 5;
            enable = !(k >= 35 && k <= 84);
            step();
            if (valid_a && first_k < 0) begin
                first_k = k;
                got_f   = int'(freq_a);
            end
        end
        enable = 1'b1;
        chk("pause_close_cycle", first_k, 150);
        chk("pause_count", got_f, 10);

        // Reset in the middle of a window that already holds 6 edges.
        do_reset(3);
        for (int k = 1; k <= 160; k++) begin
            sig_in = ((k - 1) % 10) < 5;
            step();
            if (k == G) chk("pre_reset_freq", {8'd0, freq_a}, 10);
        end
        do_reset(1);
        first_k = -1;
        for (int k = 1; k <= G + 20; k++) begin
            sig_in = ((k - 1) % 20) < 10;
            step();
            if (valid_a && first_k < 0) begin
                first_k = k;
                got_f   = int'(freq_a);
            end
        end
        chk("post_reset_close", first_k, G);
        chk("post_reset_freq", got_f, 5);

        // Randomised stimulus against the model.
        do_reset(3);
        en_hold  = 0;
        sig_hold = 0;
        fast     = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            if (i % 300 == 0) fast = ($urandom_range(0, 2) == 0);
            if (sig_hold == 0) begin
                sig_in   = ~sig_in;
                sig_hold = fast ? 1 : $urandom_range(1, 8);
            end
            sig_hold--;
            if (en_hold == 0) begin
                enable  = ($urandom_range(0, 9) != 0);
                en_hold = $urandom_range(1, 60);
            end
            en_hold--;
            reset_reset = ($urandom_range(0, 999) == 0);
            step();
        end
        reset_reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
